maze_run_ctrl: RTL and testbench



---
 rtl/maze_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 44 ++++
 rtl/maze_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_maze_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze run controller.
package maze_pkg;

    localparam int unsigned MAZE_W   = 16;
    localparam int unsigned MAZE_H   = 16;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned ADDR_W   = 2 * COORD_W;
    localparam int unsigned CNT_W    = 16;
    localparam logic        CELL_PATH = 1'b1;
    localparam logic        CELL_WALL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_READY = 3'd4
    } run_state_t;

    // Flat bitmap address of cell (x, y): x + 16*y.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered grant.
// Index 0 = VGA, index 1 = player; pointer resets to the player so VGA wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] gnt_c
);

    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;

    // Next grant: a lone requester wins, a conflict goes to the one not served last.
    always_comb begin
        gnt_d  = 2'b00;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt_d = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt_d = req;
        end
        if (gnt_d[0]) begin
            last_d = 1'b0;
        end else if (gnt_d[1]) begin
            last_d = 1'b1;
        end
    end

    // Grant and last-grant pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= 2'b00;
            last_q <= 1'b1;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign gnt_c = gnt_d;

endmodule

// File: rtl/maze_run_ctrl.sv
// Carver run sequencer with timeout, maze snapshot buffer and shared cell reads.
module maze_run_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned MAZE_W  = 16,
    parameter int unsigned MAZE_H  = 16,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_maze,
    output logic                       carver_start,
    input  logic                       carver_finish,
    input  logic [MAZE_W*MAZE_H-1:0]   carver_maze,
    output logic                       busy,
    output logic                       maze_valid,
    output logic                       timeout_err,
    input  logic                       vga_req,
    input  logic [3:0]                 vga_x,
    input  logic [3:0]                 vga_y,
    output logic                       vga_gnt,
    output logic                       vga_cell,
    input  logic                       plr_req,
    input  logic [3:0]                 plr_x,
    input  logic [3:0]                 plr_y,
    output logic                       plr_gnt,
    output logic                       plr_cell
);

    localparam int unsigned CELLS = MAZE_W * MAZE_H;

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CELLS-1:0] buf_q, buf_d;
    logic             carver_start_q, carver_start_d;
    logic             busy_q, busy_d;
    logic             maze_valid_q, maze_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             vga_cell_q, vga_cell_d;
    logic             plr_cell_q, plr_cell_d;
    logic [1:0]       gnt, gnt_c;

    // Run sequencing: handshake, settle window, timeout and snapshot.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        maze_valid_d  = maze_valid_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (new_maze) begin
                    state_d       = ST_START;
                    cnt_d         = '0;
                    maze_valid_d  = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else if (!carver_finish && cnt_q != '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else if (carver_finish && cnt_q >= CNT_W'(SETTLE)) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                buf_d        = carver_maze;
                state_d      = ST_READY;
                maze_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        carver_start_d = (state_d == ST_START);
        busy_d         = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_LATCH);
    end

    // Read data for the requester being granted; walls until a full maze is held.
    always_comb begin
        vga_cell_d = CELL_WALL;
        plr_cell_d = CELL_WALL;
        if (gnt_c[0] && maze_valid_q) begin
            vga_cell_d = buf_q[cell_addr(vga_x, vga_y)];
        end
        if (gnt_c[1] && maze_valid_q) begin
            plr_cell_d = buf_q[cell_addr(plr_x, plr_y)];
        end
    end

    // State, counter, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            buf_q          <= '0;
            carver_start_q <= 1'b0;
            busy_q         <= 1'b0;
            maze_valid_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            vga_cell_q     <= 1'b0;
            plr_cell_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_q          <= buf_d;
            carver_start_q <= carver_start_d;
            busy_q         <= busy_d;
            maze_valid_q   <= maze_valid_d;
            timeout_err_q  <= timeout_err_d;
            vga_cell_q     <= vga_cell_d;
            plr_cell_q     <= plr_cell_d;
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({plr_req, vga_req}),
        .gnt   (gnt),
        .gnt_c (gnt_c)
    );

    assign carver_start = carver_start_q;
    assign busy         = busy_q;
    assign maze_valid   = maze_valid_q;
    assign timeout_err  = timeout_err_q;
    assign vga_gnt      = gnt[0];
    assign plr_gnt      = gnt[1];
    assign vga_cell     = vga_cell_q;
    assign plr_cell     = plr_cell_q;

endmodule

// File: tb/tb_maze_run_ctrl.sv
// Directed bench for maze_run_ctrl with a small behavioural carver.
module tb_maze_run_ctrl;

    localparam int FIN_AT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         new_maze;
    logic         carver_start;
    logic         carver_finish;
    logic [255:0] carver_maze;
    logic         busy, maze_valid, timeout_err;
    logic         vga_req, vga_gnt, vga_cell;
    logic [3:0]   vga_x, vga_y;
    logic         plr_req, plr_gnt, plr_cell;
    logic [3:0]   plr_x, plr_y;

    int           checks = 0;
    int           passed = 0;
    logic [255:0] pat;
    logic         never_fin;
    int           rc;

    always #5 clk = ~clk;

    maze_run_ctrl #(.MAZE_W(16), .MAZE_H(16), .SETTLE(4), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .new_maze(new_maze),
        .carver_start(carver_start), .carver_finish(carver_finish), .carver_maze(carver_maze),
        .busy(busy), .maze_valid(maze_valid), .timeout_err(timeout_err),
        .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y), .vga_gnt(vga_gnt), .vga_cell(vga_cell),
        .plr_req(plr_req), .plr_x(plr_x), .plr_y(plr_y), .plr_gnt(plr_gnt), .plr_cell(plr_cell)
    );

    // Carver model: finish drops a cycle after start, false finish in RUN cycle 1,
    // real finish from RUN cycle FIN_AT (unless never_fin).
    always @(posedge clk) begin
        if (rst) begin
            carver_finish <= 1'b1;
            rc            <= 0;
        end else if (carver_start) begin
            carver_finish <= 1'b0;
            rc            <= 0;
        end else begin
            rc            <= rc + 1;
            carver_finish <= (rc + 1 == 1) || (!never_fin && rc + 1 >= FIN_AT);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        vga_req = 1'b0; plr_req = 1'b0;
        vga_x = 4'd0; vga_y = 4'd0; plr_x = 4'd0; plr_y = 4'd0;
    endtask

    // Pulses new_maze (edge 0 samples it), optionally again at edge nm_at, and watches the run.
    task automatic watch_run(input int nm_at, output int first_valid, output int rises,
                             output logic start_e0, output logic valid_e5, output logic busy_e6);
        logic prev;
        prev = carver_start;
        first_valid = -1; rises = 0; start_e0 = 1'b0; valid_e5 = 1'b1; busy_e6 = 1'b0;
        @(negedge clk);
        new_maze = 1'b1;
        step();
        for (int e = 0; e < 80 && first_valid < 0; e++) begin
            if (carver_start && !prev) rises++;
            prev = carver_start;
            if (e == 0) start_e0 = carver_start;
            if (e == 5) valid_e5 = maze_valid;
            if (e == 6) busy_e6 = busy;
            if (maze_valid) first_valid = e;
            new_maze = (e + 1 == nm_at);
            step();
        end
        new_maze = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; new_maze = 1'b0; never_fin = 1'b0; carver_maze = pat;
        clear_reqs();
        step(); step();
        checks++;
        if ({carver_start, busy, maze_valid, timeout_err, vga_gnt, vga_cell, plr_gnt, plr_cell} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {carver_start, busy, maze_valid, timeout_err, vga_gnt, vga_cell, plr_gnt, plr_cell});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_conflict();
        @(negedge clk);
        vga_req = 1'b1; plr_req = 1'b1; plr_x = 4'd1; plr_y = 4'd2;
        step();
        checks++;
        if ({vga_gnt, plr_gnt, vga_cell, plr_cell} !== 4'b1000)
            $display("FAIL first_conflict: got gnt v/p %b%b cell %b%b expected 10 00",
                     vga_gnt, plr_gnt, vga_cell, plr_cell);
        else passed++;
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_read_before_valid();
        @(negedge clk);
        vga_req = 1'b1; vga_x = 4'd3; vga_y = 4'd2;
        step();
        checks++;
        if ({vga_gnt, vga_cell, plr_gnt} !== 3'b100)
            $display("FAIL read_before_valid: got gnt %b cell %b plr_gnt %b expected 1 0 0",
                     vga_gnt, vga_cell, plr_gnt);
        else passed++;
        @(negedge clk);
        clear_reqs();
        step();
        checks++;
        if (vga_gnt !== 1'b0) $display("FAIL gnt_pulse: got %b expected 0", vga_gnt);
        else passed++;
    endtask

    task automatic test_normal_run();
        int fv, rises, bad;
        logic s0, v5, b6;
        watch_run(-1, fv, rises, s0, v5, b6);
        checks++;
        if (s0 !== 1'b1) $display("FAIL start_raised: got %b expected 1", s0); else passed++;
        checks++;
        if (v5 !== 1'b0 || b6 !== 1'b1)
            $display("FAIL false_finish: got valid@5 %b busy@6 %b expected 0 1", v5, b6);
        else passed++;
        checks++;
        if (fv !== 44) $display("FAIL run_length: got %0d expected 44", fv); else passed++;
        checks++;
        if (busy !== 1'b0 || carver_start !== 1'b0)
            $display("FAIL ready_outputs: got busy %b start %b expected 0 0", busy, carver_start);
        else passed++;
        // Snapshot must hold after the carver output changes.
        carver_maze = ~pat;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            vga_req = 1'b1; vga_x = 4'(i % 16); vga_y = 4'(i / 16);
            step();
            if (vga_gnt !== 1'b1 || vga_cell !== pat[i]) bad++;
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bad !== 0) $display("FAIL buffer_contents: got %0d bad cells expected 0", bad); else passed++;
    endtask

    task automatic test_arbitration();
        logic [1:0] expg [4];
        expg[0] = 2'b10; expg[1] = 2'b01; expg[2] = 2'b10; expg[3] = 2'b01;
        @(negedge clk);
        plr_req = 1'b1; plr_x = 4'd1; plr_y = 4'd2;
        step();
        checks++;
        if ({plr_gnt, plr_cell, vga_gnt} !== 3'b110)
            $display("FAIL plr_read_0x21: got gnt %b cell %b vga_gnt %b expected 1 1 0",
                     plr_gnt, plr_cell, vga_gnt);
        else passed++;
        @(negedge clk);
        vga_req = 1'b1; vga_x = 4'd0; vga_y = 4'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({vga_gnt, plr_gnt} !== expg[c] ||
                vga_cell !== (expg[c][1] & pat[0]) || plr_cell !== expg[c][0])
                $display("FAIL arb_cycle%0d: got gnt v/p %b%b cell %b%b expected %b cell %b%b",
                         c, vga_gnt, plr_gnt, vga_cell, plr_cell, expg[c],
                         expg[c][1] & pat[0], expg[c][0]);
            else passed++;
        end
        @(negedge clk);
        clear_reqs();
        step();
    endtask

    task automatic test_new_maze_during_run();
        int fv, rises;
        logic s0, v5, b6;
        carver_maze = pat;
        watch_run(10, fv, rises, s0, v5, b6);
        checks++;
        if (rises !== 1 || fv !== 44)
            $display("FAIL new_maze_ignored: got rises %0d valid@%0d expected 1 44", rises, fv);
        else passed++;
    endtask

    task automatic test_timeout();
        never_fin = 1'b1;
        @(negedge clk);
        new_maze = 1'b1;
        step();
        new_maze = 1'b0;
        checks++;
        if (maze_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL valid_cleared: got valid %b busy %b expected 0 1", maze_valid, busy);
        else passed++;
        for (int e = 1; e <= 102; e++) step();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL before_timeout: got err %b busy %b expected 0 1", timeout_err, busy);
        else passed++;
        step();
        checks++;
        if ({timeout_err, busy, maze_valid} !== 3'b100)
            $display("FAIL timeout: got err/busy/valid %b expected 100", {timeout_err, busy, maze_valid});
        else passed++;
        @(negedge clk);
        plr_req = 1'b1; plr_x = 4'd1; plr_y = 4'd2;
        step();
        checks++;
        if (plr_gnt !== 1'b1 || plr_cell !== 1'b0)
            $display("FAIL read_after_timeout: got gnt %b cell %b expected 1 0", plr_gnt, plr_cell);
        else passed++;
        @(negedge clk);
        clear_reqs();
        never_fin = 1'b0;
        new_maze = 1'b1;
        step();
        new_maze = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || carver_start !== 1'b1)
            $display("FAIL err_cleared: got err %b start %b expected 0 1", timeout_err, carver_start);
        else passed++;
    endtask

    // Continues the run begun at the end of test_timeout (now just after edge 0).
    task automatic test_reset_mid_run();
        int fv, rises;
        logic s0, v5, b6;
        for (int e = 1; e <= 12; e++) step();
        checks++;
        if (busy !== 1'b1 || carver_start !== 1'b0)
            $display("FAIL in_run: got busy %b start %b expected 1 0", busy, carver_start);
        else passed++;
        rst = 1'b1;
        step();
        checks++;
        if ({carver_start, busy, maze_valid} !== 3'b000)
            $display("FAIL reset_mid_run: got start/busy/valid %b expected 000",
                     {carver_start, busy, maze_valid});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        watch_run(-1, fv, rises, s0, v5, b6);
        checks++;
        if (fv !== 44 || rises !== 1)
            $display("FAIL rerun_after_reset: got valid@%0d rises %0d expected 44 1", fv, rises);
        else passed++;
    endtask

    initial begin
        pat = {8{32'hA5C3_0F96}} ^ {32{8'h5A}};
        pat[33] = 1'b1;
        test_reset();
        test_first_conflict();
        test_read_before_valid();
        test_normal_run();
        test_arbitration();
        test_new_maze_during_run();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
